// File: rtl/spi_ram.sv
// Byte-wide RAM behind an SPI command decoder (write/read address and data pointers).
// Read data returns one cycle after the rx_valid frame; no backpressure, every rx_valid frame is consumed.
module spi_ram #(
    parameter int MEM_DEPTH = 256,
    parameter int ADDR_SIZE = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       cmd_err
);

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;
    localparam logic [ADDR_SIZE-1:0] ADDR_ONE = 1;

    logic [7:0]           mem [MEM_DEPTH];

    logic [1:0]           cmd;
    logic [7:0]           payload;

    logic [ADDR_SIZE-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_SIZE-1:0] rd_addr_q, rd_addr_d;
    logic                 wr_addr_ok_q, wr_addr_ok_d;
    logic                 rd_addr_ok_q, rd_addr_ok_d;
    logic [7:0]           tx_data_q, tx_data_d;
    logic                 tx_valid_q, tx_valid_d;
    logic                 cmd_err_q, cmd_err_d;
    logic                 mem_we;

    assign cmd     = rx_data[9:8];
    assign payload = rx_data[7:0];

    always_comb begin
        wr_addr_d    = wr_addr_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_ok_d = wr_addr_ok_q;
        rd_addr_ok_d = rd_addr_ok_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = 1'b0;
        cmd_err_d    = cmd_err_q;
        mem_we       = 1'b0;
        if (rx_valid) begin
            case (cmd)
                CMD_WR_ADDR: begin
                    wr_addr_d    = payload[ADDR_SIZE-1:0];
                    wr_addr_ok_d = 1'b1;
                end
                CMD_WR_DATA: begin
                    if (wr_addr_ok_q) begin
                        mem_we    = 1'b1;
                        wr_addr_d = wr_addr_q + ADDR_ONE;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                CMD_RD_ADDR: begin
                    rd_addr_d    = payload[ADDR_SIZE-1:0];
                    rd_addr_ok_d = 1'b1;
                end
                CMD_RD_DATA: begin
                    // Payload is a dummy byte clocked in while the slave shifts data out.
                    if (rd_addr_ok_q) begin
                        tx_data_d  = mem[rd_addr_q];
                        tx_valid_d = 1'b1;
                        rd_addr_d  = rd_addr_q + ADDR_ONE;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Memory has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_addr_q] <= payload;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_addr_q    <= '0;
            rd_addr_q    <= '0;
            wr_addr_ok_q <= 1'b0;
            rd_addr_ok_q <= 1'b0;
            tx_data_q    <= 8'h00;
            tx_valid_q   <= 1'b0;
            cmd_err_q    <= 1'b0;
        end else begin
            wr_addr_q    <= wr_addr_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_ok_q <= wr_addr_ok_d;
            rd_addr_ok_q <= rd_addr_ok_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            cmd_err_q    <= cmd_err_d;
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign cmd_err  = cmd_err_q;

endmodule
